river_crossing_game: RTL and testbench
======================================

// Module: river_crossing_game
// PURPOSE
//  Sequential controller for the farmer/cabbage/goat/wolf river-crossing puzzle.
//  - Holds bank positions {F,C,G,W} in a register (0 = start bank, 1 = far bank).
//  - Accepts one move per handshake and rejects moves that are not legal.
//  - Flags unsafe configurations, counts moves and enforces an optional move limit.
//  - Reports the game state (PLAY / LOST / WON). Sits between the board push-button/switch debouncers and the LED/7-seg display logic.
// PARAMETERS
//  CNT_W      5  width of move_count; the counter saturates at 2**CNT_W-1
//  MAX_MOVES  0  move limit; 0 = no limit; otherwise the game is LOST at this count unless it is WON
// PORTS
//  Clock       in   1      system clock, rising edge
//  Resetn      in   1      asynchronous, active-low reset
//  restart     in   1      synchronous return to the initial game, any state
//  move_valid  in   1      move request, sampled when move_ready=1
//  move_sel    in   2      passenger: 00 farmer alone, 01 cabbage, 10 goat, 11 wolf
//  move_ready  out  1      1 only in PLAY
//  pos         out  4      registered positions {F,C,G,W}
//  alarm       out  1      registered; 1 = pos is unsafe
//  illegal     out  1      one-cycle pulse: rejected move
//  timeout     out  1      1 = game LOST by reaching the move limit
//  win         out  1      1 in WON
//  lost        out  1      1 in LOST
//  move_count  out  CNT_W  count of accepted moves
// BEHAVIOUR
//  - Reset (Resetn=0, async): pos=0000, move_count=0, alarm=illegal=timeout=win=lost=0, state=PLAY.
//  - unsafe(p): (G==W && F!=G) || (C==G && F!=G).
//  - States:
//    - PLAY: move_ready=1.
//    - LOST: move_ready=0; lost=1.
//    - WON:  move_ready=0; win=1.
//  - Accept condition: move_valid & move_ready at a rising edge.
//    - Legal when move_sel==00, or when the selected passenger's bit equals F.
//    - Legal move: F and the passenger bit toggle; move_count increments (saturating).
//    - Illegal move: illegal=1 for exactly the next cycle; pos and move_count unchanged.
//  - All outputs are registered and update on the same edge as pos. Latency from move to pos/alarm/state is 1 cycle.
//  - Next-state priority after a legal move (first match wins):
//    1. unsafe(new pos) -> LOST, alarm=1.
//    2. new pos==1111 -> WON.
//    3. MAX_MOVES!=0 and new count==MAX_MOVES -> LOST, timeout=1.
//    4. Otherwise stay in PLAY.
//  - A win on the MAX_MOVES-th move is WON, not timeout.
//  - LOST/WON are sticky. move_valid is ignored there: no illegal pulse, no count change.
//  - restart (sync) is identical to reset and is effective from any state. restart overrides a simultaneous move_valid; the move is dropped.
//  - Resetn asserted mid-move: the move is lost and all outputs return to reset values immediately.
//  - move_valid held high accepts one move per cycle; no edge detection inside.
//  - Counter saturation: at 2**CNT_W-1 the count holds; further legal moves still update pos.
// TESTING
//  1. Reset, then the optimal 7 moves (10,00,11,10,01,00,10) -> pos=1111, win=1, move_count=7, alarm=0, move_ready=0.
//  2. Reset, move 01 (cabbage) -> next cycle pos=1100, alarm=1, lost=1, move_ready=0; a further move 00 is ignored.
//  3. Reset, move 10 -> pos=1010; move 11 (wolf on far bank? no, on start bank) -> illegal pulses 1 cycle, pos=1010, count=1.
//  4. MAX_MOVES=3: moves 10,00,00 -> pos=1010, count=3, lost=1, timeout=1, alarm=0.
//  5. Mid-game (count=4): restart together with move_valid -> pos=0000, count=0, PLAY; the move is dropped.
//  6. Mid-game: Resetn pulse asynchronous to Clock -> outputs 0 before the next edge; CNT_W=3 with 9 legal moves -> count saturates at 7.

Source files
------------

// File: rtl/river_crossing_game.sv
// Farmer/cabbage/goat/wolf river-crossing controller: bank register, move legality, safety, move limit.
// Latency: a move accepted on an edge is visible on pos/alarm/win/lost/timeout/illegal/move_count after that edge.
// Backpressure: move_ready=1 only while playing; moves offered in LOST/WON are ignored.
//
// Ports:
//   Clock, Resetn      rising-edge clock, asynchronous active-low reset
//   restart            synchronous return to the initial game (beats a simultaneous move)
//   move_valid/_sel    move request and passenger (00 farmer alone, 01 cabbage, 10 goat, 11 wolf)
//   move_ready         high in PLAY
//   pos                registered banks {F,C,G,W}, 0 = start bank, 1 = far bank
//   alarm/illegal      unsafe configuration / one-cycle rejected-move pulse
//   timeout/win/lost   game outcome flags
//   move_count         accepted legal moves, saturating
module river_crossing_game #(
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned MAX_MOVES = 0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             restart,
  input  logic             move_valid,
  input  logic [1:0]       move_sel,
  output logic             move_ready,
  output logic [3:0]       pos,
  output logic             alarm,
  output logic             illegal,
  output logic             timeout,
  output logic             win,
  output logic             lost,
  output logic [CNT_W-1:0] move_count
);

  typedef enum logic [1:0] {PLAY, LOST, WON} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [3:0]       pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             alarm_q, alarm_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic             win_q, win_d;
  logic             lost_q, lost_d;

  // Scratch values for evaluating a candidate move.
  logic [1:0]       idx;
  logic [3:0]       mask;
  logic [3:0]       npos;
  logic [CNT_W-1:0] ncnt;
  logic             legal;
  logic             unsafe_n;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= PLAY;
      pos_q     <= '0;
      cnt_q     <= '0;
      alarm_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      win_q     <= 1'b0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      cnt_q     <= cnt_d;
      alarm_q   <= alarm_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      win_q     <= win_d;
      lost_q    <= lost_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    cnt_d     = cnt_q;
    alarm_d   = alarm_q;
    illegal_d = 1'b0;
    timeout_d = timeout_q;
    win_d     = win_q;
    lost_d    = lost_q;

    // pos is {F,C,G,W}: passenger sel 01/10/11 lives at bit 2/1/0.
    idx  = 2'd3 - move_sel;
    mask = 4'b1000;
    if (move_sel != 2'b00) mask[idx] = 1'b1;
    legal    = (move_sel == 2'b00) || (pos_q[idx] == pos_q[3]);
    npos     = pos_q ^ mask;
    ncnt     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    unsafe_n = ((npos[1] == npos[0]) && (npos[3] != npos[1])) ||
               ((npos[2] == npos[1]) && (npos[3] != npos[1]));

    if (restart) begin
      state_d   = PLAY;
      pos_d     = '0;
      cnt_d     = '0;
      alarm_d   = 1'b0;
      timeout_d = 1'b0;
      win_d     = 1'b0;
      lost_d    = 1'b0;
    end else if (state_q == PLAY && move_valid) begin
      if (legal) begin
        pos_d = npos;
        cnt_d = ncnt;
        // Safety outranks a win, and a win on the last allowed move outranks timeout.
        if (unsafe_n) begin
          state_d = LOST;
          alarm_d = 1'b1;
          lost_d  = 1'b1;
        end else if (npos == 4'b1111) begin
          state_d = WON;
          win_d   = 1'b1;
        end else if (MAX_MOVES != 0 &&
                     {{(32-CNT_W){1'b0}}, ncnt} == MAX_MOVES) begin
          state_d   = LOST;
          timeout_d = 1'b1;
          lost_d    = 1'b1;
        end
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  assign move_ready = (state_q == PLAY);
  assign pos        = pos_q;
  assign alarm      = alarm_q;
  assign illegal    = illegal_q;
  assign timeout    = timeout_q;
  assign win        = win_q;
  assign lost       = lost_q;
  assign move_count = cnt_q;

endmodule

// File: tb/tb_river_crossing_game.sv
// Bench for river_crossing_game: three instances (default, 3-move limit, 3-bit counter) share stimulus.
// Each is compared every cycle with a puzzle-level reference model.
// Directed scenarios followed by a randomized run.
module tb_river_crossing_game;

  localparam int ST_PLAY = 0;
  localparam int ST_LOST = 1;
  localparam int ST_WON  = 2;

  typedef struct {
    bit farmer, cabbage, goat, wolf;
    int moves;
    int status;
    bit alarm, illegal, timeout;
  } mdl_t;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       restart = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_sel = 2'b00;

  logic       rdy0, rdy1, rdy2;
  logic [3:0] pos0, pos1, pos2;
  logic       al0, al1, al2, il0, il1, il2, to0, to1, to2;
  logic       win0, win1, win2, lost0, lost1, lost2;
  logic [4:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic [14:0] obs [3];

  int checks = 0;
  int errors = 0;
  mdl_t m [3];
  int lim  [3] = '{0, 3, 0};
  int cmax [3] = '{31, 31, 7};

  always #5 Clock = ~Clock;

  river_crossing_game #(.CNT_W(5), .MAX_MOVES(0)) dut0 (
    .Clock(Clock), .Resetn(Resetn), .restart(restart), .move_valid(move_valid),
    .move_sel(move_sel), .move_ready(rdy0), .pos(pos0), .alarm(al0), .illegal(il0),
    .timeout(to0), .win(win0), .lost(lost0), .move_count(cnt0));
  river_crossing_game #(.CNT_W(5), .MAX_MOVES(3)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .restart(restart), .move_valid(move_valid),
    .move_sel(move_sel), .move_ready(rdy1), .pos(pos1), .alarm(al1), .illegal(il1),
    .timeout(to1), .win(win1), .lost(lost1), .move_count(cnt1));
  river_crossing_game #(.CNT_W(3), .MAX_MOVES(0)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .restart(restart), .move_valid(move_valid),
    .move_sel(move_sel), .move_ready(rdy2), .pos(pos2), .alarm(al2), .illegal(il2),
    .timeout(to2), .win(win2), .lost(lost2), .move_count(cnt2));

  assign obs[0] = {rdy0, pos0, al0, il0, to0, win0, lost0, cnt0};
  assign obs[1] = {rdy1, pos1, al1, il1, to1, win1, lost1, cnt1};
  assign obs[2] = {rdy2, pos2, al2, il2, to2, win2, lost2, 2'b00, cnt2};

  function automatic mdl_t fresh();
    mdl_t s;
    s.farmer = 0; s.cabbage = 0; s.goat = 0; s.wolf = 0;
    s.moves = 0; s.status = ST_PLAY;
    s.alarm = 0; s.illegal = 0; s.timeout = 0;
    return s;
  endfunction

  // One clock edge of the puzzle, stated in terms of who is on which bank.
  function automatic mdl_t step(mdl_t s, bit rs, bit vld, bit [1:0] sel, int limit, int top);
    mdl_t n = s;
    bit with_farmer;
    n.illegal = 0;
    if (rs) return fresh();
    if (s.status != ST_PLAY || !vld) return n;
    case (sel)
      2'd1: with_farmer = (s.cabbage == s.farmer);
      2'd2: with_farmer = (s.goat == s.farmer);
      2'd3: with_farmer = (s.wolf == s.farmer);
      default: with_farmer = 1;
    endcase
    if (!with_farmer) begin
      n.illegal = 1;
      return n;
    end
    n.farmer = !s.farmer;
    if (sel == 2'd1) n.cabbage = !s.cabbage;
    if (sel == 2'd2) n.goat = !s.goat;
    if (sel == 2'd3) n.wolf = !s.wolf;
    n.moves = (s.moves >= top) ? top : s.moves + 1;
    if ((n.goat == n.wolf || n.goat == n.cabbage) && n.goat != n.farmer) begin
      n.status = ST_LOST; n.alarm = 1;
    end else if (n.farmer && n.cabbage && n.goat && n.wolf) begin
      n.status = ST_WON;
    end else if (limit != 0 && n.moves == limit) begin
      n.status = ST_LOST; n.timeout = 1;
    end
    return n;
  endfunction

  function automatic logic [14:0] exp_vec(mdl_t s);
    logic [4:0] c = 5'(s.moves);
    return {s.status == ST_PLAY, s.farmer, s.cabbage, s.goat, s.wolf,
            s.alarm, s.illegal, s.timeout, s.status == ST_WON, s.status == ST_LOST, c};
  endfunction

  // Apply inputs for one edge, advance the models, land on the next falling edge.
  task automatic do_cycle(input bit rs, input bit vld, input bit [1:0] sel);
    restart = rs; move_valid = vld; move_sel = sel;
    @(posedge Clock);
    for (int k = 0; k < 3; k++) m[k] = step(m[k], rs, vld, sel, lim[k], cmax[k]);
    @(negedge Clock);
    restart = 0; move_valid = 0; move_sel = 2'b00;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) m[k] = fresh();
    Resetn = 0;
    repeat (2) @(negedge Clock);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 15'b1_0000_00000_00000) begin
        errors++; $display("FAIL reset inst%0d: got %b want %b", k, obs[k], 15'b1_0000_00000_00000);
      end
    end
    Resetn = 1;
    @(negedge Clock);
  endtask

  task automatic test_optimal();
    bit [1:0] seq [7] = '{2'd2, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd2};
    do_cycle(1, 0, 0);
    foreach (seq[i]) begin
      do_cycle(0, 1, seq[i]);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(m[k])) begin
          errors++; $display("FAIL optimal step%0d inst%0d: got %b want %b", i, k, obs[k], exp_vec(m[k]));
        end
      end
    end
    checks++;
    if ({pos0, win0, cnt0, al0, rdy0} !== {4'b1111, 1'b1, 5'd7, 1'b0, 1'b0}) begin
      errors++; $display("FAIL optimal_final: got pos=%b win=%b cnt=%0d alarm=%b rdy=%b want 1111 1 7 0 0",
                         pos0, win0, cnt0, al0, rdy0);
    end
  endtask

  task automatic test_lose_cabbage();
    do_cycle(1, 0, 0);
    do_cycle(0, 1, 2'd1);
    checks++;
    if ({pos0, al0, lost0, rdy0} !== {4'b1100, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL cabbage_lost: got pos=%b alarm=%b lost=%b rdy=%b want 1100 1 1 0", pos0, al0, lost0, rdy0);
    end
    do_cycle(0, 1, 2'd0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== exp_vec(m[k])) begin
        errors++; $display("FAIL lost_sticky inst%0d: got %b want %b", k, obs[k], exp_vec(m[k]));
      end
    end
    checks++;
    if ({pos0, cnt0, il0} !== {4'b1100, 5'd1, 1'b0}) begin
      errors++; $display("FAIL lost_ignore: got pos=%b cnt=%0d ill=%b want 1100 1 0", pos0, cnt0, il0);
    end
  endtask

  task automatic test_illegal();
    do_cycle(1, 0, 0);
    do_cycle(0, 1, 2'd2);
    do_cycle(0, 1, 2'd3);
    checks++;
    if ({il0, pos0, cnt0} !== {1'b1, 4'b1010, 5'd1}) begin
      errors++; $display("FAIL illegal_pulse: got ill=%b pos=%b cnt=%0d want 1 1010 1", il0, pos0, cnt0);
    end
    do_cycle(0, 0, 0);
    checks++;
    if ({il0, pos0, cnt0, rdy0} !== {1'b0, 4'b1010, 5'd1, 1'b1}) begin
      errors++; $display("FAIL illegal_clear: got ill=%b pos=%b cnt=%0d rdy=%b want 0 1010 1 1", il0, pos0, cnt0, rdy0);
    end
  endtask

  task automatic test_timeout();
    bit [1:0] seq [3] = '{2'd2, 2'd0, 2'd0};
    do_cycle(1, 0, 0);
    foreach (seq[i]) do_cycle(0, 1, seq[i]);
    checks++;
    if ({pos1, cnt1, lost1, to1, al1, rdy1} !== {4'b1010, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL timeout: got pos=%b cnt=%0d lost=%b to=%b alarm=%b rdy=%b want 1010 3 1 1 0 0",
                         pos1, cnt1, lost1, to1, al1, rdy1);
    end
    checks++;
    if (obs[0] !== exp_vec(m[0])) begin
      errors++; $display("FAIL no_limit inst0: got %b want %b", obs[0], exp_vec(m[0]));
    end
  endtask

  task automatic test_restart_with_move();
    do_cycle(1, 0, 0);
    repeat (2) begin
      do_cycle(0, 1, 2'd2);
      do_cycle(0, 1, 2'd2);
    end
    checks++;
    if (cnt0 !== 5'd4) begin
      errors++; $display("FAIL restart_pre: got cnt=%0d want 4", cnt0);
    end
    do_cycle(1, 1, 2'd2);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 15'b1_0000_00000_00000) begin
        errors++; $display("FAIL restart inst%0d: got %b want %b", k, obs[k], 15'b1_0000_00000_00000);
      end
    end
  endtask

  task automatic test_async_reset();
    do_cycle(1, 0, 0);
    do_cycle(0, 1, 2'd2);
    do_cycle(0, 1, 2'd0);
    move_valid = 1; move_sel = 2'd0;
    #1 Resetn = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      m[k] = fresh();
      checks++;
      if (obs[k] !== 15'b1_0000_00000_00000) begin
        errors++; $display("FAIL async_reset inst%0d: got %b want %b", k, obs[k], 15'b1_0000_00000_00000);
      end
    end
    move_valid = 0;
    #1 Resetn = 1;
    @(negedge Clock);
    checks++;
    if (obs[0] !== exp_vec(m[0])) begin
      errors++; $display("FAIL async_release: got %b want %b", obs[0], exp_vec(m[0]));
    end
  endtask

  // move_valid held every cycle; goat shuttles, so each edge is a legal safe move.
  task automatic test_back_to_back();
    do_cycle(1, 0, 0);
    for (int i = 0; i < 9; i++) begin
      do_cycle(0, 1, 2'd2);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(m[k])) begin
          errors++; $display("FAIL back_to_back step%0d inst%0d: got %b want %b", i, k, obs[k], exp_vec(m[k]));
        end
      end
    end
    checks++;
    if ({cnt2, pos2, cnt0} !== {3'd7, 4'b1010, 5'd9}) begin
      errors++; $display("FAIL saturate: got cnt2=%0d pos2=%b cnt0=%0d want 7 1010 9", cnt2, pos2, cnt0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      do_cycle($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== exp_vec(m[k])) begin
          errors++; $display("FAIL random cyc%0d inst%0d: got %b want %b", i, k, obs[k], exp_vec(m[k]));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_optimal();
    test_lose_cabbage();
    test_illegal();
    test_timeout();
    test_restart_with_move();
    test_async_reset();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
